// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_unit
//  Purpose  : Program counter plus single-outstanding instruction fetch.
//             One 32-bit word is fetched from instruction memory per request
//             from the control FSM (fetch_en). The PC moves on retirement
//             (instr_done), either sequentially (+4) or to a branch target.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1   clock, all state on rising edge
//    rstn         in   1   asynchronous active-low reset
//    fetch_en     in   1   fetch request pulse
//    instr_done   in   1   current instruction retires; update PC
//    br_taken     in   1   with instr_done: take branch
//    br_target    in  32   branch target (aligned down to a word)
//    imem_req     out  1   instruction memory read request
//    imem_addr    out 32   word-aligned read address
//    imem_rdata   in  32   read data, valid with imem_rvalid
//    imem_rvalid  in   1   read data valid
//    inst         out 32   instruction register
//    inst_valid   out  1   one-cycle pulse: inst just loaded
//    pc           out 32   program counter
//    busy         out  1   fetch outstanding
//    fetch_err    out  1   sticky: timeout or misaligned branch target
//    retire_cnt   out 32   retired-instruction counter
// ============================================================================
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000,
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] NOP_INST = 32'h0340_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fetch_en,
  input  logic        instr_done,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic        busy,
  output logic        fetch_err,
  output logic [31:0] retire_cnt
);

  // Last WAIT cycle count before the fetch is abandoned: the counter holds
  // 0 in the first WAIT cycle, so TIMEOUT WAIT cycles end at TIMEOUT-1.
  localparam logic [15:0] C_WAIT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic        fetch_err_q, fetch_err_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;

  logic        w_misalign;
  logic        w_load;
  logic [31:0] w_load_data;
  logic        w_timeout;

  // --------------------------------------------------------------------------
  // PC / retirement path. pc_d is also the fetch address bypass, so a fetch
  // issued in the same cycle as a retirement goes to the updated PC.
  // --------------------------------------------------------------------------
  always_comb begin
    pc_d         = pc_q;
    w_misalign   = 1'b0;
    retire_cnt_d = retire_cnt_q;
    if (instr_done) begin
      retire_cnt_d = retire_cnt_q + 32'd1;
      if (br_taken) begin
        // Low target bits are dropped; the target is flagged, not rejected.
        pc_d       = {br_target[31:2], 2'b00};
        w_misalign = |br_target[1:0];
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Fetch FSM: next state and outputs.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wait_cnt_d  = wait_cnt_q;
    imem_req    = 1'b0;
    busy        = 1'b0;
    w_load      = 1'b0;
    w_load_data = inst_q;
    w_timeout   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Late responses arriving here without a request are ignored.
        if (fetch_en) begin
          imem_req   = 1'b1;
          addr_d     = pc_d;
          wait_cnt_d = 16'd0;
          if (imem_rvalid) begin
            // Zero-wait memory: the word is taken in the request cycle.
            w_load      = 1'b1;
            w_load_data = imem_rdata;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        // fetch_en is ignored here; only one fetch may be outstanding.
        imem_req = 1'b1;
        busy     = 1'b1;
        if (imem_rvalid) begin
          w_load      = 1'b1;
          w_load_data = imem_rdata;
          state_d     = S_IDLE;
        end else if (wait_cnt_q == C_WAIT_LAST) begin
          // Memory never answered: hand the FSM a harmless NOP instead.
          w_load      = 1'b1;
          w_load_data = NOP_INST;
          w_timeout   = 1'b1;
          state_d     = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Address is live (next-PC) in the request cycle, then held while waiting.
  assign imem_addr = (state_q == S_IDLE) ? pc_d : addr_q;

  always_comb begin
    inst_d       = w_load ? w_load_data : inst_q;
    inst_valid_d = w_load;
    fetch_err_d  = fetch_err_q | w_timeout | w_misalign;
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      inst_q       <= 32'd0;
      inst_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
      retire_cnt_q <= 32'd0;
      wait_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      fetch_err_q  <= fetch_err_d;
      retire_cnt_q <= retire_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign pc         = pc_q;
  assign fetch_err  = fetch_err_q;
  assign retire_cnt = retire_cnt_q;

endmodule
`default_nettype wire
